// File: rtl/ahb_rd_pkg.sv
// ---------------------------------------------------------------------------
// ahb_rd_pkg
// Shared constants and types for the AHB read-side unpacking path.
//   AHB_BUS_W  : default AHB read data width
//   PIXEL_W    : default pixel element width
//   elem_t     : one pixel element
//   rd_entry_t : one buffered read word plus the byte order it was pushed with
// ---------------------------------------------------------------------------
package ahb_rd_pkg;

    localparam int AHB_BUS_W = 32;
    localparam int PIXEL_W   = 8;

    typedef logic [PIXEL_W-1:0] elem_t;

    typedef struct packed {
        logic [AHB_BUS_W-1:0] word;
        logic                 msb_first;
    } rd_entry_t;

endpackage

// File: rtl/ahb_rd_unpack_fifo_flex_counter.sv
// ---------------------------------------------------------------------------
// flex_counter
// Up-counter with programmable rollover value and synchronous clear.
// Counts 0 .. rollover_val_i, then returns to 0 on the next enabled cycle.
// Ports:
//   clk_i          : clock
//   rst_ni         : asynchronous active-low reset
//   clear_i        : synchronous clear to 0 (priority over count_enable_i)
//   count_enable_i : advance the count this cycle
//   rollover_val_i : last value before wrapping to 0
//   count_o        : current count
//   at_rollover_o  : count_o equals rollover_val_i
// ---------------------------------------------------------------------------
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    count_enable_i,
    input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
    output logic [NUM_CNT_BITS-1:0] count_o,
    output logic                    at_rollover_o
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    assign at_rollover_o = (count_q == rollover_val_i);
    assign count_o       = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i) begin
            count_d = at_rollover_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ahb_rd_unpack_fifo.sv
// ---------------------------------------------------------------------------
// ahb_rd_unpack_fifo
// Buffers up to DEPTH AHB read words and unpacks each into BUS_W/ELEM_W
// elements on a valid/ready stream toward the pixel datapath. Each word
// carries its own byte order, chosen when it is pushed.
//
// Optional build macro: RD_UNPACK_STATS_EN adds words_consumed (16-bit,
// wrapping pop count) and drop_count (8-bit, saturating dropped-push count).
//
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   clear         : synchronous flush of contents, counters and flags
//   load_enable   : push HRDATA this cycle (dropped when full)
//   HRDATA        : read word from AHB
//   msb_first     : order of the pushed word; 1 = top slice out first
//   full, empty   : flow-control status
//   level         : number of words held
//   out_valid     : out_data valid
//   out_ready     : consumer accepts the current element
//   out_data      : current element (all ones when empty)
//   word_done     : registered pulse after the last element of a word is taken
//   overflow      : sticky, a push was attempted while full
//   words_consumed, drop_count : statistics (RD_UNPACK_STATS_EN only)
// ---------------------------------------------------------------------------
module ahb_rd_unpack_fifo
    import ahb_rd_pkg::*;
#(
    parameter int BUS_W  = AHB_BUS_W,
    parameter int ELEM_W = PIXEL_W,
    parameter int DEPTH  = 4
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       clear,
    input  logic                       load_enable,
    input  logic [BUS_W-1:0]           HRDATA,
    input  logic                       msb_first,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ELEM_W-1:0]          out_data,
    output logic                       word_done,
    output logic                       overflow
`ifdef RD_UNPACK_STATS_EN
    ,
    output logic [15:0]                words_consumed,
    output logic [7:0]                 drop_count
`endif
);

    localparam int N     = BUS_W / ELEM_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Storage and pointers
    logic [BUS_W-1:0] word_q [DEPTH];
    logic [DEPTH-1:0] msb_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             word_done_q, word_done_d;

    // Handshake and element selection
    logic             push, drop, fire, pop;
    logic [IDX_W-1:0] idx;
    logic             last_elem;
    logic [BUS_W-1:0] head_word;
    logic             head_msb;
    logic [IDX_W-1:0] sel;
    logic [ELEM_W-1:0] head_slice;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign out_valid = !empty;
    assign overflow  = overflow_q;
    assign word_done = word_done_q;

    // Push acceptance looks only at pre-cycle fullness, so a same-cycle pop
    // never frees a slot for the incoming word.
    assign push = load_enable && !full;
    assign drop = load_enable && full;
    assign fire = out_valid && out_ready;
    assign pop  = fire && last_elem;

    flex_counter #(
        .NUM_CNT_BITS (IDX_W)
    ) u_idx_cnt (
        .clk_i          (HCLK),
        .rst_ni         (HRESETn),
        .clear_i        (clear),
        .count_enable_i (fire),
        .rollover_val_i (IDX_W'(N - 1)),
        .count_o        (idx),
        .at_rollover_o  (last_elem)
    );

    // msb_first words walk from the top slice down, so map idx onto the
    // LSB-based slice number before selecting.
    always_comb begin
        head_word  = word_q[rd_ptr_q];
        head_msb   = msb_q[rd_ptr_q];
        sel        = head_msb ? (IDX_W'(N - 1) - idx) : idx;
        head_slice = '1;
        for (int k = 0; k < N; k++) begin
            if (k == int'(sel)) begin
                head_slice = head_word[k*ELEM_W +: ELEM_W];
            end
        end
    end

    assign out_data = empty ? '1 : head_slice;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        word_done_d = 1'b0;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
            word_done_d = pop;
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            word_done_q <= word_done_d;
        end
    end

    // Entries return to all ones on reset and on clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '1;
            end
            msb_q <= '1;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '1;
            end
            msb_q <= '1;
        end else if (push) begin
            word_q[wr_ptr_q] <= HRDATA;
            msb_q[wr_ptr_q]  <= msb_first;
        end
    end

`ifdef RD_UNPACK_STATS_EN
    logic [15:0] words_consumed_q, words_consumed_d;
    logic [7:0]  drop_count_q, drop_count_d;

    always_comb begin
        words_consumed_d = words_consumed_q;
        drop_count_d     = drop_count_q;
        if (clear) begin
            words_consumed_d = '0;
            drop_count_d     = '0;
        end else begin
            if (pop) begin
                words_consumed_d = words_consumed_q + 16'd1;
            end
            if (drop && (drop_count_q != 8'hFF)) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            words_consumed_q <= '0;
            drop_count_q     <= '0;
        end else begin
            words_consumed_q <= words_consumed_d;
            drop_count_q     <= drop_count_d;
        end
    end

    assign words_consumed = words_consumed_q;
    assign drop_count     = drop_count_q;
`endif

endmodule

// File: tb/tb_ahb_rd_unpack_fifo.sv
// ---------------------------------------------------------------------------
// tb_ahb_rd_unpack_fifo
// Queue-based scoreboard: every accepted push appends its elements in the
// expected output order; every accepted element removes the queue head.
// ---------------------------------------------------------------------------
module tb_ahb_rd_unpack_fifo;

    logic        HCLK;
    logic        HRESETn;
    logic        clear;
    logic        load_enable;
    logic [31:0] HRDATA;
    logic        msb_first;
    logic        full;
    logic        empty;
    logic [2:0]  level;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        word_done;
    logic        overflow;

    ahb_rd_unpack_fifo #(
        .BUS_W  (32),
        .ELEM_W (8),
        .DEPTH  (4)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .clear       (clear),
        .load_enable (load_enable),
        .HRDATA      (HRDATA),
        .msb_first   (msb_first),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .word_done   (word_done),
        .overflow    (overflow)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] exq[$];
    int         m_words;
    int         m_idx;
    logic       m_ovf;
    logic       m_wd;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exq.delete();
        m_words = 0;
        m_idx   = 0;
        m_ovf   = 1'b0;
        m_wd    = 1'b0;
    endtask

    task automatic check_outputs();
        logic [7:0] exp_data;
        exp_data = (exq.size() != 0) ? exq[0] : 8'hFF;
        check_val("out_valid", {31'd0, out_valid}, {31'd0, exq.size() != 0});
        check_val("out_data",  {24'd0, out_data},  {24'd0, exp_data});
        check_val("level",     {29'd0, level},     32'(m_words));
        check_val("full",      {31'd0, full},      {31'd0, m_words == 4});
        check_val("empty",     {31'd0, empty},     {31'd0, m_words == 0});
        check_val("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
        check_val("word_done", {31'd0, word_done}, {31'd0, m_wd});
    endtask

    // Drive one cycle of stimulus, advance the model, then check at negedge.
    task automatic cycle(input logic ld, input logic [31:0] d, input logic m,
                         input logic rdy, input logic clr);
        logic fire, pop, push, drop;
        load_enable = ld;
        HRDATA      = d;
        msb_first   = m;
        out_ready   = rdy;
        clear       = clr;
        if (clr) begin
            model_reset();
        end else begin
            fire = (m_words != 0) && rdy;
            pop  = fire && (m_idx == 3);
            push = ld && (m_words < 4);
            drop = ld && (m_words == 4);
            if (fire) begin
                void'(exq.pop_front());
                m_idx = (m_idx == 3) ? 0 : m_idx + 1;
            end
            if (push) begin
                for (int k = 0; k < 4; k++) begin
                    exq.push_back(m ? d[31-8*k -: 8] : d[8*k +: 8]);
                end
            end
            m_words = m_words + int'(push) - int'(pop);
            if (drop) m_ovf = 1'b1;
            m_wd = pop;
        end
        @(posedge HCLK);
        @(negedge HCLK);
        load_enable = 1'b0;
        clear       = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        HRESETn     = 1'b0;
        clear       = 1'b0;
        load_enable = 1'b0;
        HRDATA      = '0;
        msb_first   = 1'b0;
        out_ready   = 1'b0;
        model_reset();
        repeat (3) @(negedge HCLK);
        check_outputs();
        HRESETn = 1'b1;
        @(negedge HCLK);
        check_outputs();

        // MSB-first word streams AA BB CC DD then pulses word_done
        cycle(1'b1, 32'hAABBCCDD, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);

        // LSB-first word followed by a mixed-mode MSB-first word
        cycle(1'b1, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h11223344, 1'b1, 1'b1, 1'b0);
        idle(9, 1'b1);

        // Five pushes while stalled: fifth dropped, overflow set; then drain
        cycle(1'b1, 32'h0A0B0C0D, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h1A1B1C1D, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2A2B2C2D, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h3A3B3C3D, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h4A4B4C4D, 1'b1, 1'b0, 1'b0);
        idle(18, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Full at idx 3 with push and pop in the same cycle: push rejected
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h50515253 + 32'(i), 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
        idle(14, 1'b1);

        // Clear after partial consumption
        cycle(1'b1, 32'h61626364, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h71727374, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Clear coinciding with the last element suppresses word_done
        cycle(1'b1, 32'h81828384, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);

        // Asynchronous reset mid-word, then a fresh word starts at idx 0
        cycle(1'b1, 32'h91929394, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        #2 HRESETn = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge HCLK);
        HRESETn = 1'b1;
        cycle(1'b1, 32'h01020304, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
        end
        idle(20, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
